sad_block_param: RTL and testbench

//  Parametrised SAD engine: sum of absolute differences between an original block and a candidate block.

---
 rtl/sad_block_param.sv | 126 ++++++++++++
 tb/tb_sad_block_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sad_block_param.sv
// rtl/sad_block_param.sv - streamed SAD engine, LANES pixel pairs per beat over ROWS beats
// Optional abs-diff register stage enabled by defining SAD_PIPE_EN.
module sad_block_param #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 8,
    parameter int ROWS   = 4,
    localparam int ACC_W = WIDTH + $clog2(LANES * ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   ack,
    input  logic [LANES*WIDTH-1:0] ori,
    input  logic [LANES*WIDTH-1:0] can,
    output logic                   done,
    output logic [ACC_W-1:0]       out_sad
);

    localparam int LSUM_W = WIDTH + $clog2(LANES);
    localparam int CNT_W  = $clog2(ROWS + 1);
`ifdef SAD_PIPE_EN
    localparam int LAST_BEAT = ROWS;
`else
    localparam int LAST_BEAT = ROWS - 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               done_q;

    logic signed [WIDTH:0] diff_full [LANES];
    logic [WIDTH-1:0]      diff_d    [LANES];
    logic [WIDTH-1:0]      diff_s    [LANES];
    logic [LSUM_W-1:0]     lane_sum;
    logic [ACC_W-1:0]      acc_d;
    logic                  acc_en;

    // Differences are formed one bit wider so the sign is exact before taking magnitude.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            diff_full[i] = $signed({1'b0, ori[i*WIDTH +: WIDTH]})
                         - $signed({1'b0, can[i*WIDTH +: WIDTH]});
            diff_d[i]    = diff_full[i][WIDTH] ? WIDTH'(-diff_full[i])
                                               : diff_full[i][WIDTH-1:0];
        end
    end

`ifdef SAD_PIPE_EN
    logic [WIDTH-1:0] diff_q [LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) diff_q[i] <= '0;
        end else if (state_q == S_RUN) begin
            for (int i = 0; i < LANES; i++) diff_q[i] <= diff_d[i];
        end
    end

    // Beat 0 only fills the pipe; the final count is the drain cycle.
    always_comb begin
        diff_s = diff_q;
        acc_en = (cnt_q != '0);
    end
`else
    always_comb begin
        diff_s = diff_d;
        acc_en = 1'b1;
    end
`endif

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LSUM_W'(diff_s[i]);
        end
        acc_d = acc_q + {{(ACC_W-LSUM_W){1'b0}}, lane_sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (init) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (acc_en) acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST_BEAT)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done    = done_q;
    assign out_sad = acc_q;

endmodule

// File: tb/tb_sad_block_param.sv
// tb/tb_sad_block_param.sv - scoreboard bench for sad_block_param
module tb_sad_block_param;
    localparam int WIDTH = 8;
    localparam int LANES = 8;
    localparam int ROWS  = 4;
    localparam int ACC_W = WIDTH + $clog2(LANES * ROWS);
`ifdef SAD_PIPE_EN
    localparam int LAT = ROWS + 2;
`else
    localparam int LAT = ROWS + 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   init;
    logic                   ack;
    logic [LANES*WIDTH-1:0] ori;
    logic [LANES*WIDTH-1:0] can;
    logic                   done;
    logic [ACC_W-1:0]       out_sad;

    sad_block_param #(.WIDTH(WIDTH), .LANES(LANES), .ROWS(ROWS)) dut (
        .clk     (clk),
        .rst     (rst),
        .init    (init),
        .ack     (ack),
        .ori     (ori),
        .can     (can),
        .done    (done),
        .out_sad (out_sad)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int last_exp = 0;
    bit done_prev = 1'b0;
    int bo [ROWS][LANES];
    int bc [ROWS][LANES];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_sad();
        int s = 0;
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++)
                s += (bo[r][i] > bc[r][i]) ? bo[r][i] - bc[r][i] : bc[r][i] - bo[r][i];
        return s;
    endfunction

    task automatic drive_beat(input int r);
        for (int i = 0; i < LANES; i++) begin
            ori[i*WIDTH +: WIDTH] = WIDTH'(bo[r][i]);
            can[i*WIDTH +: WIDTH] = WIDTH'(bc[r][i]);
        end
    endtask

    task automatic drive_garbage();
        ori = {$urandom, $urandom};
        can = {$urandom, $urandom};
    endtask

    // Starts in the cycle right after an edge (+1); abort_at < 0 means run to completion.
    task automatic run_block(input bit hold_init, input int abort_at);
        int lat = 0;
        init = 1'b1;
        if (abort_at < 0) begin
            last_exp = model_sad();
            exp_q.push_back(last_exp);
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            @(posedge clk); #1;
            if (!hold_init) init = 1'b0;
            if (k == 1) check("acc_cleared_on_init", out_sad, 0);
            if (done) begin
                lat = k;
                break;
            end
            if (k - 1 < ROWS) drive_beat(k - 1);
            else drive_garbage();
            if (abort_at >= 0 && k - 1 == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst  = 1'b0;
                init = 1'b0;
                check("abort_done", done, 0);
                check("abort_out_sad", out_sad, 0);
                last_exp = 0;
                return;
            end
        end
        init = 1'b0;
        check("latency", lat, LAT);
    endtask

    task automatic do_ack(input int delay);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk); #1;
            check("done_held", done, 1);
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("done_after_ack", done, 0);
        check("out_sad_after_ack", out_sad, last_exp);
    endtask

    task automatic fill_const(input int o, input int c);
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) begin
                bo[r][i] = o;
                bc[r][i] = c;
            end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got out_sad %0d with no pending block", out_sad);
            end else begin
                check("sb_out_sad", out_sad, exp_q.pop_front());
            end
        end
        done_prev = done;
    end

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        ack  = 1'b0;
        ori  = '0;
        can  = '0;
        repeat (2) @(posedge clk);
        #1;
        init = 1'b1;
        ack  = 1'b1;
        @(posedge clk); #1;
        check("reset_done", done, 0);
        check("reset_out_sad", out_sad, 0);
        rst  = 1'b0;
        init = 1'b0;
        ack  = 1'b0;
        @(posedge clk); #1;

        fill_const(8'h5A, 8'h5A);
        run_block(1'b0, -1);
        do_ack(1);

        fill_const(8'hFF, 8'h00);
        run_block(1'b0, -1);
        check("full_scale", out_sad, 8160);
        do_ack(0);

        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) begin
                bo[r][i] = i * 10;
                bc[r][i] = 100 - i;
            end
        run_block(1'b1, -1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_done", done, 1);
            check("hold_out_sad", out_sad, last_exp);
        end
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        check("init_in_done", done, 1);
        check("init_in_done_sad", out_sad, last_exp);
        ack  = 1'b1;
        init = 1'b1;
        @(posedge clk); #1;
        ack  = 1'b0;
        init = 1'b0;
        check("ack_with_init", done, 0);
        @(posedge clk); #1;
        check("idle_after_ack", done, 0);
        check("idle_holds_sad", out_sad, last_exp);

        fill_const(8'hFF, 8'h00);
        run_block(1'b0, 2);
        @(posedge clk); #1;
        check("idle_after_abort", done, 0);
        run_block(1'b0, -1);
        do_ack(0);

        fill_const(8'h5A, 8'h5A);
        run_block(1'b0, -1);
        do_ack(2);

        for (int n = 0; n < 24; n++) begin
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < LANES; i++) begin
                    bo[r][i] = $urandom_range(0, 255);
                    bc[r][i] = $urandom_range(0, 255);
                    if (n % 6 == 5) begin
                        bo[r][i] = (i % 2 == 0) ? 255 : 0;
                        bc[r][i] = 255 - bo[r][i];
                    end
                end
            run_block(1'($urandom_range(0, 1)), -1);
            do_ack($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
